// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_ctrl_pkg: opcodes, ALU op encoding and main control bundle  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
    logic memtoreg;
    logic alusrc;
    logic illegal;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ctrl_decoder: combinational RV32 main/ALU control decode          |
// | IMM_ALU_EN enables I-type ALU decode.  Rev 1.0                    |
// +------------------------------------------------------------------+
module ctrl_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_t     alu_op,
  output logic [3:0]  funct,
  output ctrl_t       ctrl,
  output logic        rs2_used
);

  logic unused_bits;
  assign unused_bits = &{1'b0, instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    alu_op   = ALU_ADD;
    funct    = {instr[30], instr[14:12]};
    ctrl     = '0;
    rs2_used = 1'b1;
    case (instr[6:0])
      OP_R: begin
        alu_op        = ALU_FUNCT;
        ctrl.regwrite = 1'b1;
      end
      OP_LOAD: begin
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
      end
      OP_STORE: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
      end
      OP_BRANCH: begin
        alu_op      = ALU_SUB;
        ctrl.branch = 1'b1;
      end
`ifdef IMM_ALU_EN
      // bit 30 is immediate data here, not a sub/sra selector
      OP_IMM: begin
        alu_op        = ALU_FUNCT;
        funct         = {1'b0, instr[14:12]};
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        rs2_used      = 1'b0;
      end
`endif
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_ctrl_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | id_ex_ctrl_stage: ID/EX control register with handshake, flush,   |
// | load-use bubbles and bubble counter. Macro: IMM_ALU_EN. Rev 1.0   |
// +------------------------------------------------------------------+
module id_ex_ctrl_stage
  import riscv_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_valid,
  input  logic [31:0]            if_instr,
  output logic                   id_ready,
  input  logic                   flush,
  input  logic                   ex_ready,
  output logic                   ex_valid,
  output logic [1:0]             ex_alu_op,
  output logic [3:0]             ex_funct,
  output logic [4:0]             ex_rs1,
  output logic [4:0]             ex_rs2,
  output logic [4:0]             ex_rd,
  output logic                   ex_regwrite,
  output logic                   ex_memread,
  output logic                   ex_memwrite,
  output logic                   ex_branch,
  output logic                   ex_memtoreg,
  output logic                   ex_alusrc,
  output logic                   ex_illegal,
  output logic [STALL_CNT_W-1:0] stall_count
);

  alu_op_t dec_alu_op;
  logic [3:0] dec_funct;
  ctrl_t dec_ctrl;
  logic dec_rs2_used;

  ctrl_decoder u_dec (
    .instr    (if_instr),
    .alu_op   (dec_alu_op),
    .funct    (dec_funct),
    .ctrl     (dec_ctrl),
    .rs2_used (dec_rs2_used)
  );

  logic valid_q, valid_d;
  alu_op_t alu_op_q, alu_op_d;
  logic [3:0] funct_q, funct_d;
  logic [4:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  ctrl_t ctrl_q, ctrl_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic hold, hz, clear_entry;

  assign hold = valid_q & ~ex_ready;
  assign hz   = if_valid & valid_q & ctrl_q.memread & (rd_q != 5'd0) &
                ((rd_q == if_instr[19:15]) | (dec_rs2_used & (rd_q == if_instr[24:20])));
  assign clear_entry = flush | (~hold & hz);
  assign id_ready    = flush | (~hold & ~hz);

  always_comb begin
    valid_d  = valid_q;
    alu_op_d = alu_op_q;
    funct_d  = funct_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    ctrl_d   = ctrl_q;
    stall_d  = stall_q;
    if (clear_entry) begin
      valid_d  = 1'b0;
      alu_op_d = ALU_ADD;
      funct_d  = '0;
      rs1_d    = '0;
      rs2_d    = '0;
      rd_d     = '0;
      ctrl_d   = '0;
      // flush outranks the hazard, so a killed bubble is not counted
      if (!flush && !(&stall_q))
        stall_d = stall_q + 1'b1;
    end else if (!hold) begin
      valid_d = if_valid;
      if (if_valid) begin
        alu_op_d = dec_alu_op;
        funct_d  = dec_funct;
        rs1_d    = if_instr[19:15];
        rs2_d    = if_instr[24:20];
        rd_d     = if_instr[11:7];
        ctrl_d   = dec_ctrl;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      alu_op_q <= ALU_ADD;
      funct_q  <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      ctrl_q   <= '0;
      stall_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      alu_op_q <= alu_op_d;
      funct_q  <= funct_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      ctrl_q   <= ctrl_d;
      stall_q  <= stall_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_alu_op   = alu_op_q;
  assign ex_funct    = funct_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memwrite = ctrl_q.memwrite;
  assign ex_branch   = ctrl_q.branch;
  assign ex_memtoreg = ctrl_q.memtoreg;
  assign ex_alusrc   = ctrl_q.alusrc;
  assign ex_illegal  = ctrl_q.illegal;
  assign stall_count = stall_q;

endmodule
`default_nettype wire

// File: doc/id_ex_ctrl_stage.md
# id_ex_ctrl_stage

Decode-side producer of the ALU control interface: takes a 32-bit RV32 instruction from IF/ID and registers the `Alu_op`/`funct` pair plus the main control bits into the ID/EX pipeline register, where the EX-stage ALU control decoder consumes them. The stage has a valid/ready handshake on both sides and a branch flush. It inserts load-use bubbles and counts them. It sits between the IF/ID register and the EX stage.

## Interface
Parameters:
- `STALL_CNT_W`, default 16: width of the saturating bubble counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `if_valid` in 1: `if_instr` holds a valid instruction.
- `if_instr` in 32: instruction word.
- `id_ready` out 1: the stage accepts `if_instr` this cycle.
- `flush` in 1: taken branch; kill both the held entry and the incoming entry.
- `ex_ready` in 1: EX accepts the registered entry.
- `ex_valid` out 1: the registered entry is valid.
- `ex_alu_op` out 2: `00` add, `01` sub/branch, `10` funct-decoded.
- `ex_funct` out 4: `{instr[30], instr[14:12]}`.
- `ex_rs1`, `ex_rs2`, `ex_rd` out 5 each: register indices.
- `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_branch`, `ex_memtoreg`, `ex_alusrc` out 1 each: main control bits.
- `ex_illegal` out 1: the entry had an unsupported opcode; it is issued as a NOP.
- `stall_count` out `STALL_CNT_W`: number of load-use bubbles, saturating.

## Operation
Decode by opcode `instr[6:0]`:
- `0110011` (R): alu_op `10`, regwrite=1, alusrc=0.
- `0000011` (load): alu_op `00`, memread=1, memtoreg=1, regwrite=1, alusrc=1.
- `0100011` (store): alu_op `00`, memwrite=1, alusrc=1.
- `1100011` (branch): alu_op `01`, branch=1.
- Any other opcode: alu_op `00`, all enables 0, illegal=1.

`ex_funct` and the register indices are always taken from the raw instruction fields.

Hazard:
- `hz = ex_valid & ex_memread & (ex_rd != 0) & (ex_rd == if_instr[19:15] | ex_rd == if_instr[24:20])`.
- `hz` is evaluated only when `if_valid` is high.

Next-state priority, highest first:
1. `reset` → `ex_valid`=0 and every output 0.
2. `flush` → `ex_valid`=0 next edge. `id_ready`=1, so the incoming instruction is discarded.
3. Hold (`ex_valid & !ex_ready`) → all registers keep their value; `id_ready`=0.
4. Bubble (`hz`) → `ex_valid`=0 with control bits cleared; `id_ready`=0; `stall_count` increments.
5. Load → `ex_valid`=`if_valid`; fields are captured when `if_valid` is high; `id_ready`=1.

Other rules:
- When a bubble is loaded, every enable and `ex_illegal` is 0. Index fields are don't-care but are driven to 0.
- `stall_count` saturates at all-ones and does not wrap.
- Only one bubble is ever needed per hazard: the next cycle EX holds the bubble, so `hz` is 0.

## Timing
- Latency is 1 cycle: an instruction accepted on edge N appears on the `ex_*` outputs after edge N.
- `id_ready` is combinational from `flush`, `ex_valid`, `ex_ready`, `ex_memread`, `ex_rd`, `if_valid` and `if_instr`. There is no combinational path from `if_instr` to the `ex_*` outputs.
- A transfer into EX occurs on an edge where `ex_valid & ex_ready` is high.
- Throughput is 1 instruction per cycle, absent hold or hazard.
- `reset` asserted mid-stream clears the stage immediately (asynchronously). The first accept after deassertion is at the first edge with `if_valid` high.
- If `flush` and hold are active in the same cycle, flush wins and the held entry is dropped.
- If `flush` and `hz` are active in the same cycle, flush wins and `stall_count` is not incremented.

## Configuration
- `IMM_ALU_EN` defined: opcode `0010011` (I-type ALU) decodes as alu_op `10`, funct=`{1'b0, instr[14:12]}`, regwrite=1, alusrc=1. Only rs1 participates in `hz` for this opcode.
- `IMM_ALU_EN` undefined: `0010011` is treated as illegal and issued as a NOP with `ex_illegal`=1.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - opcode localparams (`OP_R`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`, `OP_IMM`);
  - the `alu_op_t` enum (`ALU_ADD`=00, `ALU_SUB`=01, `ALU_FUNCT`=10);
  - the packed struct `ctrl_t` containing the six enables plus `illegal`.
- Sub-module `ctrl_decoder` is purely combinational: instruction in, `alu_op_t`, funct and `ctrl_t` out. The top level holds the register, handshake, hazard logic and counter.

## Test plan
- R-type add `0x002081B3`, then sub `0x402081B3`, with `ex_ready`=1. Required one cycle later: alu_op=10 with funct=0000, then alu_op=10 with funct=1000; regwrite=1 and alusrc=0 for both.
- Load `lw x5,0(x1)` followed by `add x6,x5,x2`. Required: one bubble cycle with `ex_valid`=0, `id_ready`=0 during the hazard cycle, `stall_count`=1, and the add issued on the next cycle.
- Hold `ex_ready`=0 for 3 cycles with a valid store in EX. Required: outputs stable, memwrite=1, `id_ready`=0; the next instruction is accepted on the cycle `ex_ready` returns high.
- Assert `flush` during a load-use hazard. Required: `ex_valid`=0 next cycle, `stall_count` unchanged, `id_ready`=1.
- Opcode `0010011` (`addi`). With `IMM_ALU_EN`: alu_op=10, funct=0000, alusrc=1. Without it: `ex_illegal`=1 and all enables 0.
- Force `stall_count` to 0xFFFE, then trigger 3 hazards. Required: `stall_count` reads 0xFFFF and stays there. Also assert `reset` mid-stream: `ex_valid` drops immediately and `stall_count` reads 0.
